// File: rtl/path_heap_ctrl.sv
// Control FSM for a binary-heap priority queue: accepts push/pop requests, drives the
// storage write/move ports and sequences an external sift-step datapath under a watchdog.
module path_heap_ctrl #(
  parameter int CAP       = 1000,
  parameter int MAX_STEPS = 10
) (
  input  logic        system1000,
  input  logic        system1000_rstn,
  input  logic        push_valid,
  input  logic [64:0] push_data,
  output logic        push_ready,
  input  logic        pop_valid,
  output logic        pop_ready,
  output logic        res_valid,
  output logic [64:0] res_data,
  input  logic        res_ready,
  output logic        dp_wr_en,
  output logic [15:0] dp_wr_idx,
  output logic [64:0] dp_wr_data,
  output logic        dp_mv_en,
  output logic [34:0] dp_hdr_o,
  output logic        dp_step,
  input  logic [34:0] dp_hdr_i,
  input  logic [64:0] dp_root_i,
  output logic [15:0] count,
  output logic        busy,
  output logic        err
);

  localparam logic [15:0] CAP_W   = 16'(CAP);
  localparam logic [15:0] STEPS_W = 16'(MAX_STEPS);
  localparam logic [1:0]  OP_PUSH = 2'b10;
  localparam logic [1:0]  OP_POP  = 2'b01;

  typedef enum logic [1:0] {IDLE, LOAD, SIFT, RESP} state_t;

  state_t      state, state_nxt;
  logic [34:0] hdr;
  logic [15:0] steps;
  logic [64:0] wr_data;
  logic        op_push;
  logic        last_push;
  logic        push_can, pop_can, push_acc, pop_acc;
  logic        step_last, sift_exit;

  assign push_can  = system1000_rstn && (state == IDLE) && (count < CAP_W);
  assign pop_can   = system1000_rstn && (state == IDLE) && (count != 16'd0) && !res_valid;
  assign push_acc  = push_valid && push_ready;
  assign pop_acc   = pop_valid && pop_ready;
  assign step_last = (steps + 16'd1) >= STEPS_W;
  assign sift_exit = dp_hdr_i[34] || step_last;

  assign dp_hdr_o   = hdr;
  assign busy       = (state != IDLE);
  assign dp_wr_idx  = dp_wr_en ? hdr[15:0] : 16'd0;
  assign dp_wr_data = dp_wr_en ? wr_data : 65'd0;

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    push_ready = 1'b0;
    pop_ready  = 1'b0;
    dp_wr_en   = 1'b0;
    dp_mv_en   = 1'b0;
    dp_step    = 1'b0;
    case (state)
      IDLE: begin
        // On contention the op that was not served last goes first.
        push_ready = push_can && !(pop_can && pop_valid && push_valid && last_push);
        pop_ready  = pop_can && !(push_can && push_valid && pop_valid && !last_push);
        if ((push_valid && push_ready) || (pop_valid && pop_ready)) state_nxt = LOAD;
      end
      LOAD: begin
        dp_wr_en  = op_push;
        dp_mv_en  = !op_push;
        state_nxt = (!op_push && count == 16'd0) ? RESP : SIFT;
      end
      SIFT: begin
        dp_step = 1'b1;
        if (sift_exit) state_nxt = op_push ? IDLE : RESP;
      end
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Count and header move together at accept so the header size always tracks count.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      count     <= 16'd0;
      hdr       <= 35'd0;
      steps     <= 16'd0;
      wr_data   <= 65'd0;
      op_push   <= 1'b0;
      last_push <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 65'd0;
    end else begin
      if (push_acc) begin
        wr_data   <= push_data;
        op_push   <= 1'b1;
        last_push <= 1'b1;
        count     <= count + 16'd1;
        hdr       <= {1'b0, OP_PUSH, count + 16'd1, count};
      end else if (pop_acc) begin
        res_data  <= dp_root_i;
        op_push   <= 1'b0;
        last_push <= 1'b0;
        count     <= count - 16'd1;
        hdr       <= {1'b0, OP_POP, count - 16'd1, 16'd0};
      end
      if (state == LOAD) steps <= 16'd0;
      if (state == SIFT) begin
        hdr   <= dp_hdr_i;
        steps <= steps + 16'd1;
        if (step_last && !dp_hdr_i[34]) err <= 1'b1;
      end
      if (state != RESP && state_nxt == RESP)     res_valid <= 1'b1;
      else if (state == RESP && res_ready)        res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_path_heap_ctrl.sv
// Directed bench for path_heap_ctrl; the datapath is a stub echoing the header with a controllable done bit.
module tb_path_heap_ctrl;
  localparam int CAP = 4;
  localparam int MAX_STEPS = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic        push_valid, push_ready, pop_valid, pop_ready;
  logic [64:0] push_data, res_data, dp_wr_data, dp_root_i;
  logic        res_valid, res_ready, dp_wr_en, dp_mv_en, dp_step, busy, err;
  logic [15:0] dp_wr_idx, count;
  logic [34:0] dp_hdr_o, dp_hdr_i, exp_hdr;
  logic        dp_done;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  assign dp_hdr_i = {dp_done, dp_hdr_o[33:0]};

  path_heap_ctrl #(.CAP(CAP), .MAX_STEPS(MAX_STEPS)) dut (
    .system1000(clk), .system1000_rstn(rstn),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .dp_wr_en(dp_wr_en), .dp_wr_idx(dp_wr_idx), .dp_wr_data(dp_wr_data),
    .dp_mv_en(dp_mv_en), .dp_hdr_o(dp_hdr_o), .dp_step(dp_step),
    .dp_hdr_i(dp_hdr_i), .dp_root_i(dp_root_i),
    .count(count), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [64:0] d);
    push_data = d; push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_pop(input logic [64:0] root);
    dp_root_i = root; pop_valid = 1'b1;
    tick();
    pop_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!busy) break;
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%0b exp=0", res_valid); end
    total++; if (res_data !== 65'd0) begin bad++; $display("FAIL rst_res_data got=%h exp=0", res_data); end
    total++; if (dp_hdr_o !== 35'd0) begin bad++; $display("FAIL rst_hdr got=%h exp=0", dp_hdr_o); end
    total++; if ({dp_step, dp_wr_en, dp_mv_en} !== 3'b000) begin bad++; $display("FAIL rst_dp got=%b exp=000", {dp_step, dp_wr_en, dp_mv_en}); end
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL rst_push_ready got=%0b exp=0", push_ready); end
    rstn = 1'b1;
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL post_rst_push_ready got=%0b exp=1", push_ready); end
    total++; if (pop_ready !== 1'b0) begin bad++; $display("FAIL post_rst_pop_ready got=%0b exp=0", pop_ready); end
  endtask

  task automatic test_push_first();
    dp_done = 1'b1; push_data = 65'h5; push_valid = 1'b1;
    #1;
    total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL push1_ready got=%0b exp=1", push_ready); end
    tick();
    push_valid = 1'b0;
    #1;
    exp_hdr = {3'b010, 16'd1, 16'd0};
    total++; if (dp_wr_en !== 1'b1 || dp_mv_en !== 1'b0) begin bad++; $display("FAIL push1_wr_en got=%0b/%0b exp=1/0", dp_wr_en, dp_mv_en); end
    total++; if (dp_wr_idx !== 16'd0) begin bad++; $display("FAIL push1_wr_idx got=%0d exp=0", dp_wr_idx); end
    total++; if (dp_wr_data !== 65'h5) begin bad++; $display("FAIL push1_wr_data got=%h exp=5", dp_wr_data); end
    total++; if (count !== 16'd1) begin bad++; $display("FAIL push1_count got=%0d exp=1", count); end
    total++; if (dp_hdr_o !== exp_hdr) begin bad++; $display("FAIL push1_hdr got=%h exp=%h", dp_hdr_o, exp_hdr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL push1_busy_load got=%0b exp=1", busy); end
    tick();
    total++; if (dp_step !== 1'b1 || dp_wr_en !== 1'b0) begin bad++; $display("FAIL push1_sift got=%0b/%0b exp=1/0", dp_step, dp_wr_en); end
    tick();
    total++; if (busy !== 1'b0 || dp_step !== 1'b0) begin bad++; $display("FAIL push1_idle got=%0b/%0b exp=0/0", busy, dp_step); end
    total++; if (count !== 16'd1) begin bad++; $display("FAIL push1_count_end got=%0d exp=1", count); end
  endtask

  task automatic test_fill();
    do_push(65'h7);
    do_push(65'h3);
    total++; if (count !== 16'd3) begin bad++; $display("FAIL fill_count3 got=%0d exp=3", count); end
    do_push(65'h9);
    total++; if (count !== 16'd4) begin bad++; $display("FAIL fill_count4 got=%0d exp=4", count); end
    push_valid = 1'b1;
    #1;
    total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_push_ready got=%0b exp=0", push_ready); end
  endtask

  task automatic test_full_pop();
    pop_valid = 1'b1; dp_root_i = 65'h9;
    #1;
    total++; if (push_ready !== 1'b0 || pop_ready !== 1'b1) begin bad++; $display("FAIL full_arb got=%0b/%0b exp=0/1", push_ready, pop_ready); end
    tick();
    pop_valid = 1'b0;
    #1;
    exp_hdr = {3'b001, 16'd3, 16'd0};
    total++; if (dp_mv_en !== 1'b1 || dp_wr_en !== 1'b0) begin bad++; $display("FAIL pop_mv got=%0b/%0b exp=1/0", dp_mv_en, dp_wr_en); end
    total++; if (count !== 16'd3) begin bad++; $display("FAIL pop_count got=%0d exp=3", count); end
    total++; if (dp_hdr_o !== exp_hdr) begin bad++; $display("FAIL pop_hdr got=%h exp=%h", dp_hdr_o, exp_hdr); end
    tick();
    total++; if (dp_step !== 1'b1 || dp_mv_en !== 1'b0) begin bad++; $display("FAIL pop_sift got=%0b/%0b exp=1/0", dp_step, dp_mv_en); end
    tick();
    total++; if (res_valid !== 1'b1 || res_data !== 65'h9) begin bad++; $display("FAIL pop_res got=%0b/%h exp=1/9", res_valid, res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL pop_idle got=%0b/%0b exp=0/0", busy, res_valid); end
    pop_valid = 1'b1;
    #1;
    total++; if (push_ready !== 1'b1 || pop_ready !== 1'b0) begin bad++; $display("FAIL arb_push_wins got=%0b/%0b exp=1/0", push_ready, pop_ready); end
    tick();
    push_valid = 1'b0;
    total++; if (count !== 16'd4 || dp_wr_idx !== 16'd3) begin bad++; $display("FAIL arb_push_load got=%0d/%0d exp=4/3", count, dp_wr_idx); end
    tick();
    tick();
    total++; if (pop_ready !== 1'b1 || push_ready !== 1'b0) begin bad++; $display("FAIL arb_pop_next got=%0b/%0b exp=1/0", pop_ready, push_ready); end
    tick();
    pop_valid = 1'b0;
    total++; if (count !== 16'd3) begin bad++; $display("FAIL arb_pop_count got=%0d exp=3", count); end
    tick();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (busy !== 1'b0 || count !== 16'd3) begin bad++; $display("FAIL arb_end got=%0b/%0d exp=0/3", busy, count); end
  endtask

  task automatic test_resp_hold();
    do_pop(65'h1);
    do_pop(65'h2);
    total++; if (count !== 16'd1) begin bad++; $display("FAIL hold_pre_count got=%0d exp=1", count); end
    dp_root_i = 65'h1A; pop_valid = 1'b1;
    #1;
    total++; if (pop_ready !== 1'b1) begin bad++; $display("FAIL hold_pop_ready got=%0b exp=1", pop_ready); end
    tick();
    pop_valid = 1'b0; dp_root_i = 65'h0;
    #1;
    total++; if (dp_mv_en !== 1'b1 || count !== 16'd0 || dp_step !== 1'b0) begin bad++; $display("FAIL hold_load got=%0b/%0d/%0b exp=1/0/0", dp_mv_en, count, dp_step); end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (res_valid !== 1'b1 || res_data !== 65'h1A) begin bad++; $display("FAIL hold_res_%0d got=%0b/%h exp=1/1a", i, res_valid, res_data); end
      total++; if (dp_step !== 1'b0 || pop_ready !== 1'b0) begin bad++; $display("FAIL hold_quiet_%0d got=%0b/%0b exp=0/0", i, dp_step, pop_ready); end
      tick();
    end
    res_ready = 1'b1;
    #1;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL hold_last got=%0b exp=1", res_valid); end
    tick();
    res_ready = 1'b0;
    total++; if (busy !== 1'b0 || res_valid !== 1'b0 || count !== 16'd0) begin bad++; $display("FAIL hold_exit got=%0b/%0b/%0d exp=0/0/0", busy, res_valid, count); end
  endtask

  task automatic test_watchdog();
    int n;
    n = 0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wd_err_pre got=%0b exp=0", err); end
    dp_done = 1'b0; push_data = 65'h42; push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      if (dp_step) n++;
      tick();
    end
    total++; if (n != MAX_STEPS) begin bad++; $display("FAIL wd_steps got=%0d exp=%0d", n, MAX_STEPS); end
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wd_exit got=%0b/%0b exp=1/0", err, busy); end
    total++; if (count !== 16'd1) begin bad++; $display("FAIL wd_count got=%0d exp=1", count); end
    tick(); tick(); tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0b exp=1", err); end
  endtask

  task automatic test_back_to_back();
    dp_done = 1'b1;
    do_push(65'h11);
    total++; if (count !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
    push_data = 65'h12; push_valid = 1'b1; pop_valid = 1'b1; dp_root_i = 65'h3C;
    #1;
    total++; if (pop_ready !== 1'b1 || push_ready !== 1'b0) begin bad++; $display("FAIL b2b_pop_wins got=%0b/%0b exp=1/0", pop_ready, push_ready); end
    tick();
    push_valid = 1'b0; pop_valid = 1'b0;
    total++; if (count !== 16'd1 || dp_mv_en !== 1'b1) begin bad++; $display("FAIL b2b_load got=%0d/%0b exp=1/1", count, dp_mv_en); end
    tick();
    tick();
    total++; if (res_valid !== 1'b1 || res_data !== 65'h3C) begin bad++; $display("FAIL b2b_res got=%0b/%h exp=1/3c", res_valid, res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL b2b_err_kept got=%0b exp=1", err); end
  endtask

  task automatic test_reset_mid();
    dp_done = 1'b0; push_data = 65'h77; push_valid = 1'b1;
    tick();
    push_valid = 1'b0;
    tick();
    tick();
    total++; if (dp_step !== 1'b1 || count !== 16'd2) begin bad++; $display("FAIL mid_sift got=%0b/%0d exp=1/2", dp_step, count); end
    rstn = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || count !== 16'd0 || dp_step !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0b/%0d/%0b exp=0/0/0", busy, count, dp_step); end
    total++; if (err !== 1'b0 || dp_hdr_o !== 35'd0 || dp_wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_clr got=%0b/%h/%0b exp=0/0/0", err, dp_hdr_o, dp_wr_en); end
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; res_ready = 1'b0;
    push_data = 65'd0; dp_root_i = 65'd0; dp_done = 1'b1; exp_hdr = 35'd0;
    test_reset();
    test_push_first();
    test_fill();
    test_full_pop();
    test_resp_hold();
    test_watchdog();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/path_heap_ctrl.md
PATH_HEAP_CTRL -- requirements
Module: path_heap_ctrl

Interface
REQ-001 The block SHALL expose parameter CAP, default 1000, heap capacity in 65-bit entries.
REQ-002 The block SHALL expose parameter MAX_STEPS, default 10, watchdog limit on sift iterations per operation.
REQ-003 The block SHALL have port system1000  in  1  rising-edge clock.
REQ-004 The block SHALL have port system1000_rstn  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port push_valid  in  1  push request; push_data  in  65  entry to insert; push_ready  out  1  push accepted when high with push_valid.
REQ-006 The block SHALL have port pop_valid  in  1  pop request; pop_ready  out  1  pop accepted when high with pop_valid.
REQ-007 The block SHALL have port res_valid  out  1; res_data  out  65  popped root; res_ready  in  1.
REQ-008 The block SHALL have port dp_wr_en  out  1; dp_wr_idx  out  16; dp_wr_data  out  65  single-entry write into heap storage.
REQ-009 The block SHALL have port dp_mv_en  out  1  copy entry [size-1] to entry [0] in heap storage.
REQ-010 The block SHALL have port dp_hdr_o  out  35  header {st[2:0], sz[15:0], idx[15:0]} to the sift-step datapath; dp_step  out  1  commit one datapath step.
REQ-011 The block SHALL have port dp_hdr_i  in  35  next header from the datapath; dp_root_i  in  65  current entry [0].
REQ-012 The block SHALL have port count  out  16; busy  out  1; err  out  1  sticky watchdog flag.

Function
REQ-013 st encoding SHALL be {done, op[1:0]}, op 2'b10 push, 2'b01 pop, 2'b00 none.
REQ-014 FSM states SHALL be IDLE, LOAD, SIFT, RESP; busy SHALL be high in every state except IDLE.
REQ-015 push_ready SHALL be high only in IDLE with count < CAP; pop_ready only in IDLE with count > 0 and res_valid low.
REQ-016 Both requests eligible in the same IDLE cycle: the op not served last SHALL win; the other's ready SHALL be low that cycle; the last-served flag resets to pop, so push wins first.
REQ-017 Push accept cycle N: IDLE->LOAD; cycle N+1 dp_wr_en=1, dp_wr_idx=count, dp_wr_data=captured push_data, header loaded {3'b010, count+1, count}, count incremented.
REQ-018 Pop accept cycle N: res_data SHALL capture dp_root_i; IDLE->LOAD; cycle N+1 dp_mv_en=1, count decremented, header loaded {3'b001, count-1, 0}.
REQ-019 Pop leaving count 0 SHALL go LOAD->RESP directly, without SIFT.
REQ-020 In SIFT, dp_step SHALL be 1 every cycle and the header register SHALL take dp_hdr_i each cycle.
REQ-021 SIFT SHALL exit when dp_hdr_i[34]=1: push to IDLE, pop to RESP; dp_step is high in the exit cycle.
REQ-022 Step counter SHALL reset on LOAD; if MAX_STEPS steps commit without done, the block SHALL set err, go IDLE (push) or RESP (pop), count unchanged.
REQ-023 RESP SHALL hold res_valid=1 and res_data stable until res_ready=1, then go IDLE next cycle.
REQ-024 dp_wr_en, dp_mv_en SHALL be single-cycle pulses, asserted only in LOAD; mutually exclusive.
REQ-025 dp_hdr_o SHALL always reflect the header register; the sz field SHALL equal count outside IDLE.
REQ-026 count SHALL never exceed CAP nor underflow; 16-bit arithmetic, no wrap.
REQ-027 Push latency (accept to IDLE) SHALL be 2 + steps cycles; pop latency (accept to res_valid) is the same, or 2 when count reaches 0.

Reset
REQ-028 With system1000_rstn=0 at a clock edge, the FSM SHALL go IDLE; count, header, step counter, err, res_valid, res_data, dp_* outputs SHALL be 0; last-served = pop.
REQ-029 Reset mid-operation SHALL abandon the operation without completing any write; storage contents are considered empty.
REQ-030 Outputs SHALL be 0 from the first edge with reset low until the first edge with reset high.

Verification
REQ-031 Reset, push 0x5 into empty heap, datapath returns done on first step -> dp_wr_idx=0, count=1, IDLE 3 cycles after accept.
REQ-032 Push and pop valid simultaneously after reset with count=3 -> push served first, pop served next; count 4 then 3.
REQ-033 Pop with count=1, root=0x1A, res_ready low 4 cycles -> res_data=0x1A held stable, count=0, no dp_step, pop_ready low until RESP exit.
REQ-034 count=CAP with push_valid high -> push_ready stays 0; pop completes; push_ready=1 next IDLE cycle.
REQ-035 Datapath never asserts done -> exactly MAX_STEPS dp_step pulses, err=1, FSM returns IDLE; err persists until reset.
REQ-036 Reset asserted in SIFT cycle 2 of a push -> next cycle IDLE, count=0, busy=0, dp_step=0.
